// File: rtl/mem_pkg.sv
// Block-memory layout shared by the RX block writer and its neighbours:
// widths, field offsets within a stored block, and the writer's state type.
package mem_pkg;
  localparam int ADDR_W            = 8;
  localparam int BLK_PAYLOAD_BYTES = 8;
  localparam int CNT_W             = 4;   // holds 0..BLK_PAYLOAD_BYTES
  localparam int PAY_BITS          = 8 * BLK_PAYLOAD_BYTES;
  localparam int NEXT_LSB          = PAY_BITS;
  localparam int CNT_LSB           = NEXT_LSB + ADDR_W;
  localparam int LAST_BIT          = CNT_LSB + CNT_W;
  localparam int BLOCK_BITS        = LAST_BIT + 1;

  typedef enum logic [1:0] {
    ST_ALLOC      = 2'd0,
    ST_FILL       = 2'd1,
    ST_ALLOC_NEXT = 2'd2,
    ST_WRITE      = 2'd3
  } wr_state_e;

  function automatic logic [BLOCK_BITS-1:0] pack_block(
    input logic [PAY_BITS-1:0] pay,
    input logic [ADDR_W-1:0]   nxt,
    input logic [CNT_W-1:0]    cnt,
    input logic                last
  );
    return {last, cnt, nxt, pay};
  endfunction
endpackage

// File: rtl/rx_block_writer.sv
// Streams RX frame bytes into linked fixed-size memory blocks taken from a
// free list; captures MAC addresses and raises a frame descriptor on the last write.
module rx_block_writer
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_last_i,
  output logic                  rx_ready_o,
  output logic                  fl_alloc_req_o,
  input  logic                  fl_alloc_gnt_i,
  input  logic [ADDR_W-1:0]     fl_alloc_block_idx_i,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [BLOCK_BITS-1:0] mem_wdata_o,
  output logic [47:0]           rx_mac_dst_addr_o,
  output logic [47:0]           rx_mac_src_addr_o,
  output logic [ADDR_W-1:0]     data_start_addr_o,
  output logic                  eop_o
);
  wr_state_e r_state, w_state_nx;

  logic                              r_run, r_slot_pend, r_last;
  logic [ADDR_W-1:0]                 r_cur, r_next, r_start;
  logic [CNT_W-1:0]                  r_cnt, w_cnt_inc;
  logic [BLK_PAYLOAD_BYTES-1:0][7:0] r_buf;
  logic [3:0]                        r_fidx;
  logic [47:0]                       r_dst, r_src;
  logic                              w_req, w_gnt, w_accept, w_slot, w_full;

  // r_run keeps the request low during the first cycle after reset
  assign w_req     = r_run && (r_state == ST_ALLOC || r_state == ST_ALLOC_NEXT);
  assign w_gnt     = w_req && fl_alloc_gnt_i;
  assign w_accept  = rx_valid_i && (r_state == ST_FILL);
  assign w_slot    = (r_state == ST_WRITE) && r_slot_pend;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_full    = (w_cnt_inc == CNT_W'(BLK_PAYLOAD_BYTES));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_ALLOC;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_ALLOC:      if (w_gnt) w_state_nx = ST_FILL;
      ST_FILL: begin
        if (w_accept) begin
          if (rx_last_i)   w_state_nx = ST_WRITE;
          else if (w_full) w_state_nx = ST_ALLOC_NEXT;
        end
      end
      ST_ALLOC_NEXT: if (w_gnt) w_state_nx = ST_WRITE;
      ST_WRITE:      if (w_slot) w_state_nx = r_last ? ST_ALLOC : ST_FILL;
      default:       w_state_nx = ST_ALLOC;
    endcase
  end

  always_comb begin
    rx_ready_o     = 1'b0;
    fl_alloc_req_o = w_req;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    eop_o          = 1'b0;
    case (r_state)
      ST_FILL:  rx_ready_o = 1'b1;
      ST_WRITE: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = r_cur;
        mem_wdata_o = pack_block(r_buf, r_next, r_cnt, r_last);
        eop_o       = r_last;
      end
      default: ;
    endcase
  end

  assign rx_mac_dst_addr_o = r_dst;
  assign rx_mac_src_addr_o = r_src;
  assign data_start_addr_o = r_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run       <= 1'b0;
      r_slot_pend <= 1'b0;
      r_last      <= 1'b0;
      r_cur       <= '0;
      r_next      <= '0;
      r_start     <= '0;
      r_cnt       <= '0;
      r_buf       <= '0;
      r_fidx      <= '0;
      r_dst       <= '0;
      r_src       <= '0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        ST_ALLOC: begin
          // new frame: descriptor of the previous one is no longer needed
          if (w_gnt) begin
            r_cur   <= fl_alloc_block_idx_i;
            r_start <= fl_alloc_block_idx_i;
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_buf   <= '0;
            r_fidx  <= '0;
            r_dst   <= '0;
            r_src   <= '0;
          end
        end
        ST_FILL: begin
          if (w_accept) begin
            for (int j = 0; j < BLK_PAYLOAD_BYTES; j++)
              if (r_cnt == CNT_W'(j)) r_buf[j] <= rx_data_i;
            for (int j = 0; j < 6; j++)
              if (r_fidx == 4'(j)) r_dst[8*(5-j) +: 8] <= rx_data_i;
            for (int j = 6; j < 12; j++)
              if (r_fidx == 4'(j)) r_src[8*(11-j) +: 8] <= rx_data_i;
            if (r_fidx != 4'd12) r_fidx <= r_fidx + 4'd1;
            r_cnt <= w_cnt_inc;
            if (rx_last_i) begin
              r_last <= 1'b1;
              r_next <= '0;
            end
          end
        end
        ST_ALLOC_NEXT: if (w_gnt) r_next <= fl_alloc_block_idx_i;
        ST_WRITE: begin
          // grant arms the slot; the slot cycle itself closes the write
          if (w_slot) begin
            r_slot_pend <= 1'b0;
            r_cur       <= r_next;
            r_cnt       <= '0;
            r_buf       <= '0;
          end else if (mem_gnt_i) begin
            r_slot_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_block_writer.sv
// Directed bench for rx_block_writer: behavioural free list and memory
// arbiter, expected block writes kept in a scoreboard queue.
module tb_rx_block_writer;
  import mem_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  rx_valid_i, rx_last_i, rx_ready_o;
  logic [7:0]            rx_data_i;
  logic                  fl_alloc_req_o, fl_alloc_gnt_i;
  logic [ADDR_W-1:0]     fl_alloc_block_idx_i;
  logic                  mem_gnt_i, mem_we_o, eop_o;
  logic [ADDR_W-1:0]     mem_addr_o, data_start_addr_o;
  logic [BLOCK_BITS-1:0] mem_wdata_o;
  logic [47:0]           rx_mac_dst_addr_o, rx_mac_src_addr_o;

  rx_block_writer dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_last_i(rx_last_i),
    .rx_ready_o(rx_ready_o),
    .fl_alloc_req_o(fl_alloc_req_o), .fl_alloc_gnt_i(fl_alloc_gnt_i),
    .fl_alloc_block_idx_i(fl_alloc_block_idx_i),
    .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .rx_mac_dst_addr_o(rx_mac_dst_addr_o), .rx_mac_src_addr_o(rx_mac_src_addr_o),
    .data_start_addr_o(data_start_addr_o), .eop_o(eop_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0]     addr;
    logic [BLOCK_BITS-1:0] wdata;
    logic                  eop;
    logic [ADDR_W-1:0]     start;
    logic [47:0]           dst;
    logic [47:0]           src;
    int                    grants;
  } wr_t;

  wr_t               sb[$];
  logic [7:0]        frm[$];
  logic [ADDR_W-1:0] fl_list[$];
  int errors = 0, checks = 0;
  int fp = 0, mp = 0, fl_hold = 0, mem_mode = 0, cyc = 0;
  bit prev_slot = 0, slot_now = 0, pre_gnt = 0, pre_we = 0, pre_acc = 0;
  logic [ADDR_W-1:0]     pre_addr;
  logic [BLOCK_BITS-1:0] pre_wdata;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the edge, check, then drive responders.
  task automatic tick();
    wr_t e;
    pre_gnt   = mem_gnt_i;
    pre_we    = mem_we_o;
    pre_addr  = mem_addr_o;
    pre_wdata = mem_wdata_o;
    pre_acc   = rx_valid_i && rx_ready_o;
    @(posedge clk);
    #1;
    cyc++;
    slot_now = pre_gnt && pre_we && !prev_slot;
    if (prev_slot) chk("we_drop", 128'(mem_we_o), 128'(0));
    if (pre_we && !prev_slot) begin
      chk("we_held", 128'(mem_we_o), 128'(1));
      chk("addr_stable", 128'(mem_addr_o), 128'(pre_addr));
      chk("wdata_stable", 128'(mem_wdata_o), 128'(pre_wdata));
    end
    if (slot_now) begin
      chk("slot_we", 128'(mem_we_o), 128'(1));
      chk("sb_has_entry", 128'(sb.size() > 0), 128'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr_addr", 128'(mem_addr_o), 128'(e.addr));
        chk("wr_data", 128'(mem_wdata_o), 128'(e.wdata));
        chk("wr_eop", 128'(eop_o), 128'(e.eop));
        if (e.eop) begin
          chk("start_addr", 128'(data_start_addr_o), 128'(e.start));
          chk("mac_dst", 128'(rx_mac_dst_addr_o), 128'(e.dst));
          chk("mac_src", 128'(rx_mac_src_addr_o), 128'(e.src));
          chk("grants_at_eop", 128'(fp), 128'(e.grants));
        end
      end
    end
    chk("eop_only_with_we", 128'(eop_o && !mem_we_o), 128'(0));
    prev_slot = slot_now;
    if (fl_hold > 0 && fl_alloc_req_o) begin
      chk("hold_ready", 128'(rx_ready_o), 128'(0));
      chk("hold_we", 128'(mem_we_o), 128'(0));
      fl_hold--;
    end
    fl_alloc_gnt_i       = 1'b0;
    fl_alloc_block_idx_i = '0;
    if (fl_alloc_req_o && fl_hold == 0 && fp < fl_list.size()) begin
      fl_alloc_gnt_i       = 1'b1;
      fl_alloc_block_idx_i = fl_list[fp];
      fp++;
    end
    if (mem_mode == 0) mem_gnt_i = mem_we_o && !slot_now;
    else               mem_gnt_i = (cyc % 4 == 0);
  endtask

  // Push the block writes expected for the frame held in frm.
  task automatic expect_frame();
    wr_t e;
    int n, nb, c;
    logic [PAY_BITS-1:0] pay;
    logic [47:0] dst, src;
    logic [ADDR_W-1:0] nxt;
    logic last;
    n = frm.size();
    nb = (n + 7) / 8;
    dst = '0;
    src = '0;
    for (int k = 0; k < n && k < 6; k++) dst[8*(5-k) +: 8] = frm[k];
    for (int k = 6; k < n && k < 12; k++) src[8*(11-k) +: 8] = frm[k];
    for (int j = 0; j < nb; j++) begin
      c = (n - 8*j > 8) ? 8 : n - 8*j;
      pay = '0;
      for (int b = 0; b < c; b++) pay[8*b +: 8] = frm[8*j + b];
      last = (j == nb - 1);
      nxt = last ? '0 : fl_list[mp + j + 1];
      e.addr   = fl_list[mp + j];
      e.wdata  = {last, CNT_W'(c), nxt, pay};
      e.eop    = last;
      e.start  = fl_list[mp];
      e.dst    = dst;
      e.src    = src;
      e.grants = mp + nb;
      sb.push_back(e);
    end
    mp += nb;
  endtask

  task automatic send_bytes(input bit with_last);
    int t;
    for (int i = 0; i < frm.size(); i++) begin
      rx_valid_i = 1'b1;
      rx_data_i  = frm[i];
      rx_last_i  = with_last && (i == frm.size() - 1);
      t = 0;
      do begin
        tick();
        t++;
      end while (!pre_acc && t < 200);
      chk("rx_accept", 128'(pre_acc), 128'(1));
    end
    rx_valid_i = 1'b0;
    rx_last_i  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 400) begin
      tick();
      t++;
    end
    chk("drain", 128'(sb.size()), 128'(0));
    repeat (4) tick();
  endtask

  task automatic make_frame(input int n, input logic [7:0] base);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(base + 8'(i));
  endtask

  initial begin
    fl_list = '{8'h05, 8'h09, 8'h0C, 8'h11, 8'h14, 8'h1A,
                8'h22, 8'h2B, 8'h30, 8'h37, 8'h3C, 8'h41};
    rst_n = 1'b0;
    rx_valid_i = 1'b0; rx_data_i = '0; rx_last_i = 1'b0;
    fl_alloc_gnt_i = 1'b0; fl_alloc_block_idx_i = '0; mem_gnt_i = 1'b0;

    tick(); tick();
    chk("rst_req", 128'(fl_alloc_req_o), 128'(0));
    chk("rst_ready", 128'(rx_ready_o), 128'(0));
    chk("rst_we", 128'(mem_we_o), 128'(0));
    chk("rst_eop", 128'(eop_o), 128'(0));
    chk("rst_dst", 128'(rx_mac_dst_addr_o), 128'(0));
    chk("rst_start", 128'(data_start_addr_o), 128'(0));
    rst_n = 1'b1;
    tick();
    chk("req_after_reset", 128'(fl_alloc_req_o), 128'(1));

    // 14-byte frame across two blocks
    make_frame(14, 8'h00);
    expect_frame();
    send_bytes(1);
    drain();
    chk("prealloc_count", 128'(fp), 128'(3));
    chk("prealloc_req_low", 128'(fl_alloc_req_o), 128'(0));
    chk("prealloc_ready", 128'(rx_ready_o), 128'(1));

    // exact two-block frame with a sparse memory grant
    mem_mode = 1;
    make_frame(16, 8'h10);
    expect_frame();
    send_bytes(1);
    drain();

    // runt frame
    frm = '{8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE};
    expect_frame();
    send_bytes(1);
    drain();

    // free list stalls while a full block waits for its successor
    mem_mode = 0;
    fl_hold = 20;
    make_frame(10, 8'h60);
    expect_frame();
    send_bytes(1);
    drain();
    chk("hold_consumed", 128'(fl_hold), 128'(0));

    // reset mid-frame: partial frame discarded
    make_frame(4, 8'h50);
    send_bytes(0);
    rst_n = 1'b0;
    tick();
    chk("midrst_we", 128'(mem_we_o), 128'(0));
    chk("midrst_eop", 128'(eop_o), 128'(0));
    chk("midrst_ready", 128'(rx_ready_o), 128'(0));
    rst_n = 1'b1;
    mp = fp;
    tick();
    chk("midrst_req", 128'(fl_alloc_req_o), 128'(1));
    make_frame(9, 8'h70);
    expect_frame();
    send_bytes(1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
